drisc_bus_bridge: RTL and testbench

Parametrised bus bridge between the drisc core's memory pads and a handshaked memory/peripheral port. It converts single-cycle core read and write requests into a valid/ready request channel with a separate read-response channel. It posts writes into a small FIFO so the core does not wait on them, and stalls the core on reads until data returns. It generates byte strobes from size and address, traps misaligned accesses, and bounds every transaction with a timeout.

---
 rtl/drisc_bus_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_drisc_bus_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drisc_bus_bridge.sv
// drisc core pads to valid/ready memory port bridge.
// Posts writes through a small FIFO, stalls reads until data returns.
module drisc_bus_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   core_address,
  input  logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [1:0]              core_data_size,
  input  logic                    core_read,
  input  logic                    core_write,
  output logic [DATA_WIDTH-1:0]   core_data_in,
  output logic                    core_stall,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_strb,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    bus_error,
  input  logic                    error_clear
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  localparam int PW = $clog2(WBUF_DEPTH) + 1;
  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [15:0]             tmo_q, tmo_d;
  logic [PW-1:0]           wptr_q, rptr_q;

  logic [ADDR_WIDTH-1:0]   fa_q [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]   fd_q [WBUF_DEPTH];
  logic [SW-1:0]           fs_q [WBUF_DEPTH];

  logic [OW-1:0]           off;
  logic                    mis;
  logic [SW-1:0]           base;
  logic [DATA_WIDTH-1:0]   mask;
  logic [SW-1:0]           req_strb;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    empty, full;
  logic                    push, pop;
  logic                    rd_mis, wr_mis;
  logic                    waiting, expire;

  assign off = core_address[OW-1:0];

  always_comb begin
    mis  = 1'b0;
    base = '0;
    mask = '0;
    unique case (core_data_size)
      2'd0: begin
        base[0]   = 1'b1;
        mask[7:0] = '1;
      end
      2'd1: begin
        mis        = off[0];
        base[1:0]  = '1;
        mask[15:0] = '1;
      end
      2'd2: begin
        mis        = |off[1:0];
        base[3:0]  = '1;
        mask[31:0] = '1;
      end
      default: begin
        mis        = 1'b1;
        base[3:0]  = '1;
        mask[31:0] = '1;
      end
    endcase
  end

  assign req_strb  = base << off;
  assign req_wdata = core_data_out << {off, 3'b000};
  assign req_addr  = {core_address[ADDR_WIDTH-1:OW], {OW{1'b0}}};

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

  // Misaligned reads complete in the cycle they are presented.
  assign rd_mis = core_read && mis && (state_q == IDLE);
  assign wr_mis = core_write && mis;

  assign core_stall = (core_read && !rd_mis && state_q != RD_DONE) ||
                      (core_write && !mis && full);
  assign push = core_write && !mis && !core_stall;

  assign core_data_in = rd_mis ? '1 : rdata_q;
  assign bus_error    = err_q;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_strb  = '0;
    pop       = 1'b0;
    expire    = 1'b0;
    waiting   = 1'b0;
    unique case (state_q)
      IDLE, DRAIN: begin
        if (!empty) begin
          mem_valid = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = fa_q[rptr_q[PW-2:0]];
          mem_wdata = fd_q[rptr_q[PW-2:0]];
          mem_strb  = fs_q[rptr_q[PW-2:0]];
          waiting   = 1'b1;
          if (mem_ready) begin
            pop = 1'b1;
          end else if (tmo_q == TMAX) begin
            pop    = 1'b1;
            expire = 1'b1;
          end
        end
        if (state_q == IDLE) begin
          if (core_read && !mis)
            state_d = empty ? RD_REQ : DRAIN;
        end else if (empty) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = req_addr;
        mem_strb  = req_strb;
        waiting   = 1'b1;
        if (mem_ready) begin
          state_d = RD_WAIT;
        end else if (tmo_q == TMAX) begin
          expire  = 1'b1;
          rdata_d = '1;
          state_d = RD_DONE;
        end
      end
      RD_WAIT: begin
        waiting = 1'b1;
        if (mem_rvalid) begin
          rdata_d = (mem_rdata >> {off, 3'b000}) & mask;
          state_d = RD_DONE;
        end else if (tmo_q == TMAX) begin
          expire  = 1'b1;
          rdata_d = '1;
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_mis || wr_mis || expire)
      err_d = 1'b1;
    else if (error_clear)
      err_d = 1'b0;
    else
      err_d = err_q;

    if (state_d != state_q || pop || !waiting)
      tmo_d = '0;
    else
      tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      wptr_q  <= wptr_q + PW'(push);
      rptr_q  <= rptr_q + PW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fa_q[wptr_q[PW-2:0]] <= req_addr;
      fd_q[wptr_q[PW-2:0]] <= req_wdata;
      fs_q[wptr_q[PW-2:0]] <= req_strb;
    end
  end

endmodule

// File: tb/tb_drisc_bus_bridge.sv
// Self-checking bench for drisc_bus_bridge.
// Memory-side transactions are checked against a queue of expected requests.
module tb_drisc_bus_bridge;
  logic        clock;
  logic        reset;
  logic [31:0] core_address;
  logic [31:0] core_data_out;
  logic [1:0]  core_data_size;
  logic        core_read;
  logic        core_write;
  logic [31:0] core_data_in;
  logic        core_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_error;
  logic        error_clear;

  drisc_bus_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .WBUF_DEPTH(4),
    .TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .core_address(core_address),
    .core_data_out(core_data_out),
    .core_data_size(core_data_size),
    .core_read(core_read),
    .core_write(core_write),
    .core_data_in(core_data_in),
    .core_stall(core_stall),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_strb(mem_strb),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .bus_error(bus_error),
    .error_clear(error_clear)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mtx_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] din;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  mtx_t        sb[$];
  vec_t        vt[8];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_data = '0;
  logic        pend = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory model and request monitor, sampled mid-cycle
  initial begin
    mtx_t e;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (mem_valid && mem_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", {mem_we, mem_addr[30:0]}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_strb", 32'(mem_strb), 32'(e.strb));
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      mem_rvalid = pend;
      mem_rdata  = pend ? rd_data : 32'h0;
      pend = mem_valid && mem_ready && !mem_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] rd, input logic [3:0] es,
                         input logic [31:0] ed, input int est,
                         input logic psh);
    int n;
    rd_data        = rd;
    core_address   = a;
    core_data_size = sz;
    core_read      = 1'b1;
    if (psh) sb.push_back('{1'b0, a & ~32'h3, 32'h0, es});
    #1;
    n = 0;
    while (core_stall && n < 60) begin
      tick();
      n++;
    end
    chk("rd_stall_cycles", 32'(n), 32'(est));
    chk("rd_data", core_data_in, ed);
    tick();
    core_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, input logic [31:0] ew,
                          input logic [3:0] es, input logic mis);
    int n;
    core_address   = a;
    core_data_size = sz;
    core_data_out  = d;
    core_write     = 1'b1;
    #1;
    n = 0;
    while (core_stall && n < 60) begin
      tick();
      n++;
    end
    chk("wr_stall_cycles", 32'(n), 32'h0);
    if (!mis) sb.push_back('{1'b1, a & ~32'h3, ew, es});
    tick();
    core_write = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 32'h100, 2'd2, 32'h0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vt[1] = '{1'b0, 32'h103, 2'd0, 32'h0, 32'h11223344, 4'h8, 32'h00000011};
    vt[2] = '{1'b0, 32'h102, 2'd1, 32'h0, 32'h11223344, 4'hC, 32'h00001122};
    vt[3] = '{1'b0, 32'h101, 2'd0, 32'h0, 32'hA5B6C7D8, 4'h2, 32'h000000C7};
    vt[4] = '{1'b1, 32'h200, 2'd2, 32'h12345678, 32'h0, 4'hF, 32'h12345678};
    vt[5] = '{1'b1, 32'h205, 2'd0, 32'h000000AB, 32'h0, 4'h2, 32'h0000AB00};
    vt[6] = '{1'b1, 32'h20A, 2'd1, 32'h0000BEEF, 32'h0, 4'hC, 32'hBEEF0000};
    vt[7] = '{1'b0, 32'h300, 2'd1, 32'h0, 32'hCAFEF00D, 4'h3, 32'h0000F00D};

    reset          = 1'b0;
    core_address   = '0;
    core_data_out  = '0;
    core_data_size = '0;
    core_read      = 1'b0;
    core_write     = 1'b0;
    mem_ready      = 1'b0;
    error_clear    = 1'b0;
    repeat (2) tick();
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_core_stall", 32'(core_stall), 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_core_data_in", core_data_in, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_strb", 32'(mem_strb), 32'h0);
    reset = 1'b1;
    tick();

    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].we)
        do_write(vt[i].addr, vt[i].size, vt[i].din, vt[i].exp,
                 vt[i].strb, 1'b0);
      else
        do_read(vt[i].addr, vt[i].size, vt[i].rdata, vt[i].strb,
                vt[i].exp, 3, 1'b1);
      tick();
    end

    // Fill the write buffer with the port blocked
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int n;
      core_address   = 32'h400 + 32'(4 * i);
      core_data_size = 2'd2;
      core_data_out  = 32'(i + 1);
      core_write     = 1'b1;
      #1;
      chk("post_stall", 32'(core_stall), 32'(i == 4));
      if (i == 4) begin
        mem_ready = 1'b1;
        n = 0;
        while (core_stall && n < 10) begin
          tick();
          n++;
        end
        chk("post_unstall_cycles", 32'(n), 32'h1);
      end
      sb.push_back('{1'b1, 32'h400 + 32'(4 * i), 32'(i + 1), 4'hF});
      tick();
    end
    core_write = 1'b0;
    repeat (6) tick();
    chk("post_no_error", 32'(bus_error), 32'h0);
    chk("post_drained", 32'(sb.size()), 32'h0);

    // Read must wait behind two posted writes
    mem_ready = 1'b0;
    do_write(32'h500, 2'd2, 32'hAAAA5555, 32'hAAAA5555, 4'hF, 1'b0);
    do_write(32'h504, 2'd2, 32'h5555AAAA, 32'h5555AAAA, 4'hF, 1'b0);
    mem_ready = 1'b1;
    do_read(32'h700, 2'd2, 32'h01020304, 4'hF, 32'h01020304, 5, 1'b1);
    tick();

    do_write(32'h201, 2'd1, 32'h00001234, 32'h0, 4'h0, 1'b1);
    chk("mis_wr_no_valid", 32'(mem_valid), 32'h0);
    chk("mis_wr_error", 32'(bus_error), 32'h1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("err_cleared", 32'(bus_error), 32'h0);

    error_clear = 1'b1;
    do_write(32'h303, 2'd2, 32'h0, 32'h0, 4'h0, 1'b1);
    error_clear = 1'b0;
    chk("err_set_over_clear", 32'(bus_error), 32'h1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;

    do_read(32'h102, 2'd2, 32'h0, 4'h0, 32'hFFFFFFFF, 0, 1'b0);
    chk("mis_rd_error", 32'(bus_error), 32'h1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("err_cleared2", 32'(bus_error), 32'h0);

    do_read(32'h3FC, 2'd3, 32'h0, 4'h0, 32'hFFFFFFFF, 0, 1'b0);
    chk("size3_error", 32'(bus_error), 32'h1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;

    mem_ready = 1'b0;
    do_read(32'h800, 2'd2, 32'h0, 4'h0, 32'hFFFFFFFF, 9, 1'b0);
    chk("tmo_error", 32'(bus_error), 32'h1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;

    // Reset lands after the read is accepted, before its response
    mem_ready      = 1'b1;
    rd_data        = 32'h55AA55AA;
    core_address   = 32'h600;
    core_data_size = 2'd2;
    core_read      = 1'b1;
    sb.push_back('{1'b0, 32'h600, 32'h0, 4'hF});
    tick();
    tick();
    reset     = 1'b0;
    core_read = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(mem_valid), 32'h0);
    chk("mid_rst_stall", 32'(core_stall), 32'h0);
    chk("mid_rst_error", 32'(bus_error), 32'h0);
    chk("mid_rst_data", core_data_in, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    chk("late_rvalid_data", core_data_in, 32'h0);
    chk("late_rvalid_valid", 32'(mem_valid), 32'h0);

    do_read(32'h104, 2'd2, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 3, 1'b1);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
